// File: rtl/rle_pkg.sv
// Shared constants and types for the JPEG run-length encoder/decoder pair.
// Symbols are {run[13:10], value[9:0]}; EOB and ZRL are reserved encodings.
package rle_pkg;

  localparam int unsigned RUN_W = 4;
  localparam int unsigned VAL_W = 10;
  localparam int unsigned SYM_W = RUN_W + VAL_W;
  localparam int unsigned IDX_W = 6;  // zig-zag position 0..63
  localparam int unsigned CNT_W = 5;  // zero counter, holds up to ZRL_RUN

  localparam logic [SYM_W-1:0] EOB_SYM = 14'h0000;
  localparam logic [SYM_W-1:0] ZRL_SYM = 14'h3C00;
  localparam int unsigned      ZRL_RUN = 16;

  typedef enum logic [1:0] {
    StIdle,
    StZeros,
    StFill
  } state_e;

  typedef enum logic [1:0] {
    ClsEob,
    ClsZrl,
    ClsVal,
    ClsIll
  } sym_class_e;

endpackage

// File: rtl/rle_sym_classify.sv
// Combinational decode of one RLE symbol.
//   sym_i   : raw symbol {run, value}
//   cls_o   : symbol class (sym_class_e encoding)
//   zeros_o : zeros to emit before the value (run, or ZRL_RUN for ZRL)
//   val_o   : coefficient value field
module rle_sym_classify
  import rle_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  output logic [1:0]       cls_o,
  output logic [CNT_W-1:0] zeros_o,
  output logic [VAL_W-1:0] val_o
);

  always_comb begin
    cls_o   = ClsVal;
    zeros_o = {1'b0, sym_i[SYM_W-1:VAL_W]};
    val_o   = sym_i[VAL_W-1:0];
    if (sym_i == EOB_SYM) begin
      cls_o   = ClsEob;
      zeros_o = '0;
    end else if (sym_i == ZRL_SYM) begin
      cls_o   = ClsZrl;
      zeros_o = CNT_W'(ZRL_RUN);
    end else if (sym_i[VAL_W-1:0] == '0) begin
      // zero value with run 1..14 has no meaning
      cls_o = ClsIll;
    end
  end

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (run, value) symbols into one 10-bit coefficient
// per cycle in zig-zag order, 64 per block.
//   clk, reset             : clock, async active-high reset
//   sym_in/valid/ready     : symbol input handshake
//   coef_out/valid/ready   : coefficient output handshake
//   coef_idx, coef_last    : zig-zag position of coef_out, high at index 63
//   err                    : pulse when an illegal or overflowing symbol is accepted
module rle_decoder #(
  parameter int unsigned RUN_W   = 4,
  parameter int unsigned VAL_W   = 10,
  parameter int unsigned BLK_LEN = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RUN_W+VAL_W-1:0] sym_in,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  output logic [VAL_W-1:0]       coef_out,
  output logic                   coef_valid,
  input  logic                   coef_ready,
  output logic [5:0]             coef_idx,
  output logic                   coef_last,
  output logic                   err
);

  import rle_pkg::*;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BLK_LEN - 1);

  state_e             state_q, state_d;
  logic [VAL_W-1:0]   coef_q, coef_d, pend_val_q, pend_val_d;
  logic               valid_q, valid_d, last_q, last_d, pend_q, pend_d;
  logic [IDX_W-1:0]   idx_q, idx_d, pos_q, pos_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         cls;
  logic [CNT_W-1:0]   zeros;
  logic [VAL_W-1:0]   val;
  logic               out_free, accept, ovf, load;
  logic [VAL_W-1:0]   load_coef;
  logic [6:0]         need, zl;

  rle_sym_classify u_classify (
    .sym_i  (sym_in),
    .cls_o  (cls),
    .zeros_o(zeros),
    .val_o  (val)
  );

  // pos_q is the index the next loaded coefficient takes; idx_q is the one on the output.
  assign out_free  = !valid_q || coef_ready;
  assign sym_ready = (state_q == StIdle) && out_free;
  assign accept    = sym_valid && sym_ready;
  assign need      = 7'(pos_q) + 7'(zeros) + 7'(val != '0);
  assign ovf       = ((cls == ClsVal) || (cls == ClsZrl)) && (need > 7'(BLK_LEN));
  assign err       = accept && ((cls == ClsIll) || ovf);

  always_comb begin
    state_d    = state_q;
    coef_d     = coef_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    last_d     = last_q;
    pos_d      = pos_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    load       = 1'b0;
    load_coef  = '0;
    zl         = '0;

    // a drained slot goes empty unless something is loaded below
    if (out_free) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cls)
            ClsVal, ClsZrl: begin
              load = 1'b1;
              if (zeros == '0) begin
                load_coef = val;
              end else begin
                // truncated symbols only fill zeros to the end of the block
                zl         = ovf ? (7'(BLK_LEN) - 7'(pos_q)) : 7'(zeros);
                cnt_d      = CNT_W'(zl - 7'd1);
                pend_d     = !ovf && (val != '0);
                pend_val_d = val;
                if ((cnt_d != '0) || pend_d) state_d = StZeros;
              end
            end
            ClsEob: begin
              load = 1'b1;
              if (pos_q != LastIdx) state_d = StFill;
            end
            default: ;  // illegal: consumed, nothing emitted
          endcase
        end
      end
      StZeros: begin
        if (out_free) begin
          load = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if ((cnt_q == CNT_W'(1)) && !pend_q) state_d = StIdle;
          end else begin
            load_coef = pend_val_q;
            pend_d    = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      StFill: begin
        if (out_free) begin
          load = 1'b1;
          if (pos_q == LastIdx) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      coef_d  = load_coef;
      valid_d = 1'b1;
      idx_d   = pos_q;
      last_d  = (pos_q == LastIdx);
      pos_d   = (pos_q == LastIdx) ? '0 : pos_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      coef_q     <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      pos_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      coef_q     <= coef_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign coef_out   = coef_q;
  assign coef_valid = valid_q;
  assign coef_idx   = idx_q;
  assign coef_last  = last_q;

endmodule
